// File: rtl/computer_pkg.sv
// Shared encodings for computer_core: instruction classes, ALU ops, jump
// conditions, flag bit positions and the run/halt state type.
package computer_pkg;

  typedef enum logic [2:0] {
    CLS_NOP   = 3'd0,
    CLS_ALU_A = 3'd1,
    CLS_ALU_B = 3'd2,
    CLS_STORE = 3'd3,
    CLS_LOAD  = 3'd4,
    CLS_JMP   = 3'd5,
    CLS_HALT  = 3'd6,
    CLS_RSVD  = 3'd7
  } cls_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOT = 3'd5,
    ALU_SHL = 3'd6,
    ALU_SHR = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    JC_ALWAYS = 3'd0,
    JC_Z      = 3'd1,
    JC_NZ     = 3'd2,
    JC_N      = 3'd3,
    JC_NN     = 3'd4,
    JC_C      = 3'd5,
    JC_V      = 3'd6,
    JC_NEVER  = 3'd7
  } jcond_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_p.sv
// Parametrised combinational ALU: result plus {Z,N,C,V} computed on the
// DATA_W-bit result. C is borrow for SUB and the shifted-out bit for shifts.
module alu_p
  import computer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  alu_op_e           i_op,
  output logic [DATA_W-1:0] o_result,
  output logic [3:0]        o_flags
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] w_res;
  logic              w_c;
  logic              w_v;

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (i_op)
      ALU_ADD: begin
        {w_c, w_res} = {1'b0, i_a} + {1'b0, i_b};
        w_v = (i_a[MSB] == i_b[MSB]) && (w_res[MSB] != i_a[MSB]);
      end
      ALU_SUB: begin
        w_res = i_a - i_b;
        w_c   = (i_a < i_b);
        w_v   = (i_a[MSB] != i_b[MSB]) && (w_res[MSB] != i_a[MSB]);
      end
      ALU_AND: w_res = i_a & i_b;
      ALU_OR:  w_res = i_a | i_b;
      ALU_XOR: w_res = i_a ^ i_b;
      ALU_NOT: w_res = ~i_a;
      ALU_SHL: begin
        w_res = {i_a[MSB-1:0], 1'b0};
        w_c   = i_a[MSB];
      end
      ALU_SHR: begin
        w_res = {1'b0, i_a[MSB:1]};
        w_c   = i_a[0];
      end
      default: w_res = '0;
    endcase
  end

  always_comb begin
    o_result        = w_res;
    o_flags         = '0;
    o_flags[FLAG_Z] = (w_res == '0);
    o_flags[FLAG_N] = w_res[MSB];
    o_flags[FLAG_C] = w_c;
    o_flags[FLAG_V] = w_v;
  end

endmodule

// File: rtl/computer_core.sv
// Single-cycle two-register accumulator core with registered flags, internal
// data memory, conditional jumps and a HALT state left only through reset.
module computer_core
  import computer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int DMEM_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W+7:0] imem_data,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] rega_out,
  output logic [DATA_W-1:0] regb_out,
  output logic [3:0]        flags,
  output logic              halted
);

  localparam int DMEM_AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [3:0]        r_flags;
  logic [DATA_W-1:0] r_dmem [DMEM_DEPTH];
  state_e            r_state;

  logic [6:0]         w_opcode;
  cls_e               w_cls;
  logic [DATA_W-1:0]  w_k;
  logic [DATA_W-1:0]  w_opb;
  logic [DATA_W-1:0]  w_alu_res;
  logic [3:0]         w_alu_flags;
  logic [DMEM_AW-1:0] w_dmem_idx;
  logic [ADDR_W-1:0]  w_jmp_tgt;
  logic [ADDR_W-1:0]  w_pc_next;
  logic               w_taken;
  logic               w_run;
  state_e             w_state_next;
  logic               w_unused_rsv;

  assign w_opcode     = imem_data[DATA_W+7:DATA_W+1];
  assign w_unused_rsv = imem_data[DATA_W];
  assign w_cls        = cls_e'(w_opcode[6:4]);
  assign w_k          = imem_data[DATA_W-1:0];
  assign w_opb        = w_opcode[3] ? w_k : r_b;
  assign w_dmem_idx   = w_k[DMEM_AW-1:0];

  generate
    if (ADDR_W > DATA_W) begin : g_tgt_ext
      assign w_jmp_tgt = {{(ADDR_W-DATA_W){1'b0}}, w_k};
    end else begin : g_tgt_trunc
      assign w_jmp_tgt = w_k[ADDR_W-1:0];
    end
  endgenerate

  alu_p #(.DATA_W(DATA_W)) u_alu (
    .i_a      (r_a),
    .i_b      (w_opb),
    .i_op     (alu_op_e'(w_opcode[2:0])),
    .o_result (w_alu_res),
    .o_flags  (w_alu_flags)
  );

  // Conditions look at the registered flags, i.e. the previous ALU result.
  always_comb begin
    w_taken = 1'b0;
    case (jcond_e'(w_opcode[2:0]))
      JC_ALWAYS: w_taken = 1'b1;
      JC_Z:      w_taken = r_flags[FLAG_Z];
      JC_NZ:     w_taken = !r_flags[FLAG_Z];
      JC_N:      w_taken = r_flags[FLAG_N];
      JC_NN:     w_taken = !r_flags[FLAG_N];
      JC_C:      w_taken = r_flags[FLAG_C];
      JC_V:      w_taken = r_flags[FLAG_V];
      default:   w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_pc_next = r_pc + ADDR_W'(1);
    if (w_cls == CLS_HALT) begin
      w_pc_next = r_pc;
    end else if (w_cls == CLS_JMP && w_taken) begin
      w_pc_next = w_jmp_tgt;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_run        = (r_state == ST_RUN);
    if (w_run && w_cls == CLS_HALT) begin
      w_state_next = ST_HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_flags <= '0;
      for (int i = 0; i < DMEM_DEPTH; i++) begin
        r_dmem[i] <= '0;
      end
    end else if (w_run) begin
      r_pc <= w_pc_next;
      case (w_cls)
        CLS_ALU_A: begin
          r_a     <= w_alu_res;
          r_flags <= w_alu_flags;
        end
        CLS_ALU_B: begin
          r_b     <= w_alu_res;
          r_flags <= w_alu_flags;
        end
        CLS_STORE: r_dmem[w_dmem_idx] <= r_a;
        CLS_LOAD:  r_a <= r_dmem[w_dmem_idx];
        default: ;
      endcase
    end
  end

  assign imem_addr = r_pc;
  assign alu_out   = w_alu_res;
  assign rega_out  = r_a;
  assign regb_out  = r_b;
  assign flags     = r_flags;
  assign halted    = (r_state == ST_HALT);

endmodule
